// File: rtl/rle_pkg.sv
// Shared types and constants for the RLE stream arbiter.
package rle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [7:0] FLUSH_BYTE_DEFAULT = 8'h00;

  // Pick a separator that can never extend the run formed by the packet's final byte.
  function automatic logic [7:0] sep_byte(input logic [7:0] flush_byte,
                                          input logic [7:0] last_byte);
    return (last_byte == flush_byte) ? ~flush_byte : flush_byte;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]         req,
  input  logic [$clog2(N_SRC)-1:0] ptr,
  output logic [$clog2(N_SRC)-1:0] gnt_idx,
  output logic                     any_req
);

  localparam int IDX_W = $clog2(N_SRC);

  int               idx;
  logic [IDX_W-1:0] cand;

  // Walk the rotated order from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_idx = '0;
    any_req = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      cand = IDX_W'(idx);
      if (req[cand]) begin
        gnt_idx = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rle_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding N byte streams into one RLE
// compressor, appending a run-breaking separator byte after every packet.
module rle_stream_arbiter
  import rle_pkg::*;
#(
  parameter int         N_SRC      = 4,
  parameter logic [7:0] FLUSH_BYTE = FLUSH_BYTE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC*8-1:0]       src_data,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [N_SRC-1:0]         src_last,
  output logic [N_SRC-1:0]         src_ready,
  output logic [7:0]               rle_data_in,
  output logic                     rle_valid_in,
  output logic [$clog2(N_SRC)-1:0] rle_src,
  output logic                     busy
);

  localparam int               IDX_W    = $clog2(N_SRC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRC - 1);

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] grant_q;
  logic [7:0]       last_byte_q;
  logic [7:0]       rle_data_q;
  logic             rle_valid_q;
  logic [IDX_W-1:0] rle_src_q;

  logic [IDX_W-1:0] rr_idx;
  logic             rr_any;
  logic [7:0]       cur_byte;
  logic             xfer;

  rr_arbiter #(.N_SRC(N_SRC)) u_rr (
    .req     (src_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .any_req (rr_any)
  );

  assign cur_byte = src_data[{grant_q, 3'b000} +: 8];
  assign xfer     = (state_q == GRANT) && src_valid[grant_q];

  // Ready is a pure decode of registered state, so it is one-hot only while granted.
  assign src_ready    = (state_q == GRANT) ? (N_SRC'(1) << grant_q) : '0;
  assign busy         = (state_q != IDLE);
  assign rle_data_in  = rle_data_q;
  assign rle_valid_in = rle_valid_q;
  assign rle_src      = rle_src_q;

  // Arbitration FSM with registered compressor-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      last_byte_q <= 8'h00;
      rle_data_q  <= 8'h00;
      rle_valid_q <= 1'b0;
      rle_src_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rle_valid_q <= 1'b0;
          if (rr_any) begin
            grant_q <= rr_idx;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) begin
            rle_data_q  <= cur_byte;
            rle_valid_q <= 1'b1;
            rle_src_q   <= grant_q;
            last_byte_q <= cur_byte;
            if (src_last[grant_q]) state_q <= FLUSH;
          end else begin
            rle_valid_q <= 1'b0;
          end
        end
        FLUSH: begin
          rle_data_q  <= sep_byte(FLUSH_BYTE, last_byte_q);
          rle_valid_q <= 1'b1;
          rle_src_q   <= grant_q;
          ptr_q       <= (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
          state_q     <= IDLE;
        end
        default: begin
          rle_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rle_stream_arbiter.sv
// Scoreboard bench: scenarios push hand-computed output bytes, a negedge
// monitor pops and compares every byte the arbiter presents.
module tb_rle_stream_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*8-1:0] src_data = '0;
  logic [N-1:0]   src_valid = '0;
  logic [N-1:0]   src_last = '0;
  logic [N-1:0]   src_ready;
  logic [7:0]     rle_data_in;
  logic           rle_valid_in;
  logic [1:0]     rle_src;
  logic           busy;

  rle_stream_arbiter #(.N_SRC(N), .FLUSH_BYTE(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_last     (src_last),
    .src_ready    (src_ready),
    .rle_data_in  (rle_data_in),
    .rle_valid_in (rle_valid_in),
    .rle_src      (rle_src),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  // Per-source stimulus: bit9 = idle cycle, bit8 = last, [7:0] = byte.
  logic [9:0] sq[N][$];

  int n_tests = 0;
  int n_fail  = 0;

  logic       fire_prev = 1'b0;
  logic [1:0] fire_src  = 2'd0;
  logic [7:0] fire_byte = 8'h00;
  logic [N-1:0] gap_pop = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor first (outputs of the previous edge), then drive the next stimulus.
  always @(negedge clk) begin : drive_mon
    exp_t e;
    logic [1:0] si;
    if (!rst) begin
      if (fire_prev) begin
        check("latency_valid", 32'(rle_valid_in), 32'd1);
        check("latency_data", 32'(rle_data_in), 32'(fire_byte));
        check("latency_src", 32'(rle_src), 32'(fire_src));
        if (sq[fire_src].size() > 0) void'(sq[fire_src].pop_front());
      end
      if (rle_valid_in) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h from src %0d, required no output", rle_data_in, rle_src);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", 32'(rle_data_in), 32'(e.data));
          check("sb_src", 32'(rle_src), 32'(e.src));
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      si = 2'(i);
      if (gap_pop[si] && sq[si].size() > 0) void'(sq[si].pop_front());
    end
    fire_prev = 1'b0;
    for (int i = 0; i < N; i++) begin
      si = 2'(i);
      gap_pop[si]                    = 1'b0;
      src_valid[si]                  = 1'b0;
      src_last[si]                   = 1'b0;
      src_data[{si, 3'b000} +: 8]    = 8'h00;
      if (sq[si].size() > 0) begin
        if (sq[si][0][9]) begin
          gap_pop[si] = 1'b1;
        end else begin
          src_valid[si]               = 1'b1;
          src_last[si]                = sq[si][0][8];
          src_data[{si, 3'b000} +: 8] = sq[si][0][7:0];
        end
      end
      if (src_valid[si] && src_ready[si]) begin
        fire_prev = 1'b1;
        fire_src  = si;
        fire_byte = sq[si][0][7:0];
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_src(input logic [1:0] s, input logic [7:0] d, input logic last);
    sq[s].push_back({1'b0, last, d});
  endtask

  task automatic push_gap(input logic [1:0] s);
    sq[s].push_back(10'h200);
  endtask

  task automatic push_exp(input logic [1:0] s, input logic [7:0] d);
    exp_t e;
    e.src  = s;
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic bit stim_pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (sq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string name);
    int c = 0;
    while ((exp_q.size() != 0 || stim_pending()) && c < 300) begin
      step();
      c++;
    end
    n_tests++;
    if (c >= 300) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d bytes outstanding, required 0", name, exp_q.size());
    end
    step(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    for (int i = 0; i < N; i++) sq[i].delete();
    exp_q.delete();
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    int  zeros;
    int  busy_cnt;
    bit  seen80;
    bit  seen81;
    bit  r3;
    bit  in_flush;

    rst = 1'b1;
    step(3);
    check("rst_valid", 32'(rle_valid_in), 32'd0);
    check("rst_data", 32'(rle_data_in), 32'h00);
    check("rst_src", 32'(rle_src), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(src_ready), 32'd0);
    rst = 1'b0;
    step(1);

    // Source 2 alone: 41,41,41,42(last) then separator 00.
    push_src(2'd2, 8'h41, 1'b0);
    push_src(2'd2, 8'h41, 1'b0);
    push_src(2'd2, 8'h41, 1'b0);
    push_src(2'd2, 8'h42, 1'b1);
    push_exp(2'd2, 8'h41);
    push_exp(2'd2, 8'h41);
    push_exp(2'd2, 8'h41);
    push_exp(2'd2, 8'h42);
    push_exp(2'd2, 8'h00);
    drain("single_src");
    check("single_src_busy_after", 32'(busy), 32'd0);

    // All four sources at once from ptr=0: served 0,1,2,3.
    do_reset();
    push_src(2'd0, 8'h10, 1'b0); push_src(2'd0, 8'h11, 1'b1);
    push_src(2'd1, 8'h20, 1'b0); push_src(2'd1, 8'h21, 1'b1);
    push_src(2'd2, 8'h30, 1'b0); push_src(2'd2, 8'h31, 1'b1);
    push_src(2'd3, 8'h50, 1'b0); push_src(2'd3, 8'h51, 1'b1);
    push_exp(2'd0, 8'h10); push_exp(2'd0, 8'h11); push_exp(2'd0, 8'h00);
    push_exp(2'd1, 8'h20); push_exp(2'd1, 8'h21); push_exp(2'd1, 8'h00);
    push_exp(2'd2, 8'h30); push_exp(2'd2, 8'h31); push_exp(2'd2, 8'h00);
    push_exp(2'd3, 8'h50); push_exp(2'd3, 8'h51); push_exp(2'd3, 8'h00);
    drain("all_four");

    // Pointer wrapped back to 0: source 0 beats source 1.
    push_src(2'd0, 8'h60, 1'b1);
    push_src(2'd1, 8'h70, 1'b1);
    push_exp(2'd0, 8'h60); push_exp(2'd0, 8'h00);
    push_exp(2'd1, 8'h70); push_exp(2'd1, 8'h00);
    drain("ptr_wrap");

    // Packet ending in the flush byte gets the inverted separator.
    push_src(2'd1, 8'h00, 1'b0);
    push_src(2'd1, 8'h00, 1'b1);
    push_exp(2'd1, 8'h00); push_exp(2'd1, 8'h00); push_exp(2'd1, 8'hFF);
    drain("sep_invert");

    // Source 0 stalls 5 cycles mid-packet; source 3 must wait.
    do_reset();
    push_src(2'd0, 8'h80, 1'b0);
    repeat (5) push_gap(2'd0);
    push_src(2'd0, 8'h81, 1'b1);
    push_src(2'd3, 8'h90, 1'b1);
    push_exp(2'd0, 8'h80); push_exp(2'd0, 8'h81); push_exp(2'd0, 8'h00);
    push_exp(2'd3, 8'h90); push_exp(2'd3, 8'h00);
    zeros = 0; seen80 = 1'b0; seen81 = 1'b0; r3 = 1'b0;
    for (int c = 0; c < 60 && !seen81; c++) begin
      step();
      if (src_ready[3]) r3 = 1'b1;
      if (rle_valid_in && rle_data_in == 8'h80) seen80 = 1'b1;
      else if (rle_valid_in && rle_data_in == 8'h81) seen81 = 1'b1;
      else if (seen80 && !rle_valid_in) zeros++;
    end
    check("gap_seen_last", 32'(seen81), 32'd1);
    check("gap_idle_cycles", 32'(zeros), 32'd5);
    check("gap_no_preempt", 32'(r3), 32'd0);
    drain("gap");

    // Reset while in FLUSH: no separator, immediate idle outputs.
    do_reset();
    push_src(2'd1, 8'h55, 1'b0);
    push_src(2'd1, 8'h56, 1'b1);
    push_exp(2'd1, 8'h55);
    push_exp(2'd1, 8'h56);
    in_flush = 1'b0;
    for (int c = 0; c < 50 && !in_flush; c++) begin
      step();
      if (busy && src_ready == '0) in_flush = 1'b1;
    end
    check("flush_reached", 32'(in_flush), 32'd1);
    rst = 1'b1;
    step();
    check("flush_rst_valid", 32'(rle_valid_in), 32'd0);
    check("flush_rst_busy", 32'(busy), 32'd0);
    check("flush_rst_data", 32'(rle_data_in), 32'h00);
    check("flush_rst_pending", 32'(exp_q.size()), 32'd0);
    step(2);
    rst = 1'b0;
    step(3);
    check("flush_rst_quiet", 32'(rle_valid_in), 32'd0);

    // First grant after reset searches from ptr=0.
    push_src(2'd2, 8'hA1, 1'b1);
    push_src(2'd0, 8'hA0, 1'b1);
    push_exp(2'd0, 8'hA0); push_exp(2'd0, 8'h00);
    push_exp(2'd2, 8'hA1); push_exp(2'd2, 8'h00);
    drain("post_rst");

    // Single-byte packet: data, separator, busy for exactly 2 cycles.
    push_src(2'd3, 8'h43, 1'b1);
    push_exp(2'd3, 8'h43);
    push_exp(2'd3, 8'h00);
    busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (busy) busy_cnt++;
    end
    check("single_byte_busy", 32'(busy_cnt), 32'd2);
    drain("single_byte");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
